// File: rtl/apb_counter_bank_if.sv
// apb_counter_bank_if: APB3 bus signals with master and slave views.
interface apb_if #(parameter int ADDR_W = 8);
  logic psel, penable, pwrite, pready, pslverr;
  logic [ADDR_W-1:0] paddr;
  logic [31:0] pwdata, prdata;
  modport master (output psel, penable, pwrite, paddr, pwdata, input prdata, pready, pslverr);
  modport slave (input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/apb_counter_bank.sv
// apb_counter_bank: APB3 slave with N_CH software-controlled up-counters (wrap/saturate, sticky overflow).
// Define EVENT_IRQ_EN to add the IRQ_MASK register at 0x84 and the irq output.
module apb_counter_bank #(
  parameter int N_CH = 4,
  parameter int CNT_W = 16,
  parameter int ADDR_W = 8
) (
  input logic clk,
  input logic rst,
  apb_if.slave bus
`ifdef EVENT_IRQ_EN
  ,
  output logic irq
`endif
);
  localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1;
  localparam int AW = ADDR_W - 2;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_nx;
  logic start, wr, is_ch, is_status, is_mask, err, pslverr;
  logic [AW-1:0] wa;
  logic [CW-1:0] ch;
  logic [31:0] rdata, prdata;
  logic [CNT_W-1:0] cnt [N_CH];
  logic [N_CH-1:0] en, wrap, status, mask, ovf, ctrl_wr, w1c;
  assign bus.prdata = prdata;
  assign bus.pslverr = pslverr;
  assign bus.pready = 1'b1;
  assign wa = bus.paddr[ADDR_W-1:2];
  assign ch = wa[CW:1];
  assign is_ch = wa < AW'(2 * N_CH);
  assign is_status = wa == AW'(32);
`ifdef EVENT_IRQ_EN
  assign is_mask = wa == AW'(33);
`else
  assign is_mask = 1'b0;
  assign mask = '0;
`endif
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // The state trails the bus by one edge: SETUP means the bus is in its ACCESS cycle.
  always_comb begin
    state_nx = state == SETUP ? ACCESS : (bus.psel && !bus.penable) ? SETUP : IDLE;
    start = state != SETUP && bus.psel && !bus.penable;
    wr = state == SETUP && bus.psel && bus.penable && bus.pwrite;
    err = !(is_ch || is_status || is_mask) || (bus.pwrite && is_ch && wa[0]);
    rdata = is_ch ? (wa[0] ? 32'(cnt[ch]) : {29'b0, wrap[ch], 1'b0, en[ch]})
          : is_status ? 32'(status) : is_mask ? 32'(mask) : 32'b0;
    w1c = wr && is_status ? bus.pwdata[N_CH-1:0] : '0;
    for (int i = 0; i < N_CH; i++) begin
      ctrl_wr[i] = wr && is_ch && !wa[0] && ch == CW'(i);
      ovf[i] = en[i] && cnt[i] == '1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      prdata <= '0;
      pslverr <= 1'b0;
      status <= '0;
      en <= '0;
      wrap <= '0;
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else begin
      prdata <= start && !err && !bus.pwrite ? rdata : 32'b0;
      pslverr <= start && err;
      status <= (status & ~w1c) | ovf;
      for (int i = 0; i < N_CH; i++) begin
        if (ctrl_wr[i]) begin
          en[i] <= bus.pwdata[0];
          wrap[i] <= bus.pwdata[2];
        end
        cnt[i] <= ctrl_wr[i] && bus.pwdata[1] ? '0 : !en[i] ? cnt[i]
                : ovf[i] ? (wrap[i] ? '0 : cnt[i]) : cnt[i] + 1'b1;
      end
    end
  end
`ifdef EVENT_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      mask <= '0;
      irq <= 1'b0;
    end else begin
      if (wr && is_mask) mask <= bus.pwdata[N_CH-1:0];
      irq <= |(status & mask);
    end
  end
`endif
endmodule

// File: tb/tb_apb_counter_bank.sv
// tb_apb_counter_bank: directed and randomized APB traffic against a register-level model (N_CH=4, CNT_W=4).
module tb_apb_counter_bank;
`ifdef EVENT_IRQ_EN
  localparam bit HAS_IRQ = 1'b1;
  logic irq;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  int nvec = 0, nerr = 0;
  int m_cnt [4];
  bit m_en [4], m_wrap [4], m_irq;
  logic [3:0] m_st, m_mask;
  logic [7:0] addrs [13] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h80, 8'h84, 8'h88, 8'h40, 8'hFC};
  apb_if #(.ADDR_W(8)) bus ();
  apb_counter_bank #(.N_CH(4), .CNT_W(4), .ADDR_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
`ifdef EVENT_IRQ_EN
    ,
    .irq(irq)
`endif
  );
  always #5 clk = ~clk;

  task automatic tick(input bit w, input logic [7:0] a, input logic [31:0] d);
    logic [3:0] ovf;
    bit nirq;
    @(posedge clk);
    if (rst) begin
      for (int c = 0; c < 4; c++) begin m_cnt[c] = 0; m_en[c] = 0; m_wrap[c] = 0; end
      m_st = 0; m_mask = 0; m_irq = 0;
    end else begin
      ovf = 0;
      nirq = |(m_st & m_mask);
      for (int c = 0; c < 4; c++)
        if (m_en[c]) begin
          if (m_cnt[c] == 15) begin ovf[c] = 1; m_cnt[c] = m_wrap[c] ? 0 : 15; end
          else m_cnt[c]++;
        end
      if (w) begin
        if (a < 8'h20 && !a[2]) begin
          m_en[a[4:3]] = d[0];
          m_wrap[a[4:3]] = d[2];
          if (d[1]) m_cnt[a[4:3]] = 0;
        end else if (a[7:2] == 6'h20) m_st = m_st & ~d[3:0];
        else if (a[7:2] == 6'h21 && HAS_IRQ) m_mask = d[3:0];
      end
      m_st = m_st | ovf;
      m_irq = nirq;
    end
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 8'h00, 32'h0);
  endtask

  task automatic m_read(input logic [7:0] a, input bit w, output logic [31:0] d, output bit e);
    int c = int'(a[4:3]);
    d = 0; e = 0;
    if (a < 8'h20) begin
      if (a[2]) begin if (w) e = 1; else d = 32'(m_cnt[c]); end
      else d = {29'b0, m_wrap[c], 1'b0, m_en[c]};
    end else if (a[7:2] == 6'h20) d = 32'(m_st);
    else if (a[7:2] == 6'h21 && HAS_IRQ) d = 32'(m_mask);
    else e = 1;
    if (w || e) d = 0;
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output bit e, output bit ee);
    logic [31:0] dd;
    m_read(a, 1, dd, ee);
    bus.psel = 1; bus.penable = 0; bus.pwrite = 1; bus.paddr = a; bus.pwdata = d;
    tick(0, a, d);
    bus.penable = 1;
    e = bus.pslverr;
    tick(1, a, d);
    bus.psel = 0; bus.penable = 0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output bit e, output bit r,
                          output logic [31:0] ed, output bit ee);
    m_read(a, 0, ed, ee);
    bus.psel = 1; bus.penable = 0; bus.pwrite = 0; bus.paddr = a; bus.pwdata = $urandom;
    tick(0, a, 0);
    bus.penable = 1;
    d = bus.prdata; e = bus.pslverr; r = bus.pready;
    tick(0, a, 0);
    bus.psel = 0; bus.penable = 0;
  endtask

  task automatic do_reset;
    rst = 1;
    idle(2);
    rst = 0;
  endtask

  task automatic test_reset;
    logic [31:0] d, ed;
    bit e, ee, r;
    do_reset();
    if (bus.prdata !== 32'h0 || bus.pslverr !== 1'b0) begin
      $display("FAIL reset_outputs: prdata=%h pslverr=%b want 0/0", bus.prdata, bus.pslverr); nerr++;
    end
    nvec++;
    for (int k = 0; k < 9; k++) begin
      apb_read(addrs[k], d, e, r, ed, ee);
      if (d !== 32'h0 || e !== 1'b0 || r !== 1'b1) begin
        $display("FAIL reset_read[%h]: data=%h err=%b rdy=%b want 0/0/1", addrs[k], d, e, r); nerr++;
      end
      nvec++;
    end
    bus.psel = 1; bus.penable = 0; bus.pwrite = 1; bus.paddr = 8'h00; bus.pwdata = 32'h5;
    tick(0, 8'h00, 32'h5);
    bus.penable = 1; rst = 1;
    tick(1, 8'h00, 32'h5);
    rst = 0; bus.psel = 0; bus.penable = 0;
    apb_read(8'h00, d, e, r, ed, ee);
    if (d !== 32'h0 || e !== 1'b0) begin
      $display("FAIL reset_abort: ctrl=%h err=%b want 0/0", d, e); nerr++;
    end
    nvec++;
  endtask

  task automatic test_wrap;
    logic [31:0] d, ed;
    bit e, ee, r;
    do_reset();
    apb_write(8'h00, 32'h5, e, ee);
    idle(18);
    apb_read(8'h04, d, e, r, ed, ee);
    if (d !== ed) begin $display("FAIL wrap_count: got %h want %h", d, ed); nerr++; end
    nvec++;
    apb_read(8'h80, d, e, r, ed, ee);
    if (d !== 32'h1 || d !== ed) begin $display("FAIL wrap_status: got %h want 1 (model %h)", d, ed); nerr++; end
    nvec++;
    apb_write(8'h00, 32'h4, e, ee);
    apb_write(8'h80, 32'h1, e, ee);
    apb_read(8'h80, d, e, r, ed, ee);
    if (d !== 32'h0) begin $display("FAIL wrap_w1c: got %h want 0", d); nerr++; end
    nvec++;
  endtask

  task automatic test_saturate;
    logic [31:0] d, ed;
    bit e, ee, r;
    do_reset();
    apb_write(8'h08, 32'h1, e, ee);
    idle(20);
    apb_read(8'h0C, d, e, r, ed, ee);
    if (d !== 32'hF || d !== ed) begin $display("FAIL sat_count: got %h want f (model %h)", d, ed); nerr++; end
    nvec++;
    apb_read(8'h80, d, e, r, ed, ee);
    if (d[1] !== 1'b1 || d !== ed) begin $display("FAIL sat_status: got %h want %h", d, ed); nerr++; end
    nvec++;
  endtask

  task automatic test_clear;
    logic [31:0] d, ed;
    bit e, ee, r;
    do_reset();
    apb_write(8'h10, 32'h1, e, ee);
    for (int k = 0; k < 20 && m_cnt[2] != 7; k++) idle(1);
    apb_write(8'h10, 32'h3, e, ee);
    apb_read(8'h14, d, e, r, ed, ee);
    if (d !== 32'h0 || d !== ed) begin $display("FAIL clr_count: got %h want 0 (model %h)", d, ed); nerr++; end
    nvec++;
    apb_read(8'h10, d, e, r, ed, ee);
    if (d !== 32'h1) begin $display("FAIL clr_ctrl: got %h want 1", d); nerr++; end
    nvec++;
    apb_read(8'h14, d, e, r, ed, ee);
    if (d !== ed || d == 32'h0) begin $display("FAIL clr_resume: got %h want %h", d, ed); nerr++; end
    nvec++;
  endtask

  task automatic test_errors;
    logic [31:0] d, ed;
    bit e, ee, r;
    apb_read(8'h40, d, e, r, ed, ee);
    if (d !== 32'h0 || e !== 1'b1) begin $display("FAIL err_unmapped: data=%h err=%b want 0/1", d, e); nerr++; end
    nvec++;
    apb_write(8'h04, 32'h7, e, ee);
    if (e !== 1'b1) begin $display("FAIL err_ro_write: err=%b want 1", e); nerr++; end
    nvec++;
    apb_write(8'h84, 32'h0, e, ee);
    if (e !== !HAS_IRQ) begin $display("FAIL err_mask: err=%b want %b", e, !HAS_IRQ); nerr++; end
    nvec++;
    apb_read(8'h04, d, e, r, ed, ee);
    if (d !== ed || e !== 1'b0) begin $display("FAIL err_nochange: got %h want %h", d, ed); nerr++; end
    nvec++;
  endtask

  task automatic test_protocol;
    logic [31:0] d, ed;
    bit e, ee, r;
    do_reset();
    bus.psel = 1; bus.penable = 1; bus.pwrite = 1; bus.paddr = 8'h18; bus.pwdata = 32'h5;
    tick(0, 8'h18, 32'h5);
    bus.psel = 0; bus.penable = 0;
    idle(1);
    apb_read(8'h18, d, e, r, ed, ee);
    if (d !== 32'h0) begin $display("FAIL proto_ignored: got %h want 0", d); nerr++; end
    nvec++;
    if (bus.prdata !== 32'h0) begin $display("FAIL prdata_idle: got %h want 0", bus.prdata); nerr++; end
    nvec++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] d, ed;
    bit e, ee, r;
    apb_write(8'h18, 32'h5, e, ee);
    apb_read(8'h18, d, e, r, ed, ee);
    if (d !== 32'h5) begin $display("FAIL b2b_ctrl: got %h want 5", d); nerr++; end
    nvec++;
    apb_read(8'h1C, d, e, r, ed, ee);
    if (d !== ed) begin $display("FAIL b2b_count: got %h want %h", d, ed); nerr++; end
    nvec++;
  endtask

`ifdef EVENT_IRQ_EN
  task automatic test_irq;
    bit e, ee;
    do_reset();
    apb_write(8'h84, 32'h1, e, ee);
    apb_write(8'h00, 32'h5, e, ee);
    for (int k = 0; k < 40 && !m_st[0]; k++) idle(1);
    if (irq !== 1'b0) begin $display("FAIL irq_same_cycle: got %b want 0", irq); nerr++; end
    nvec++;
    idle(1);
    if (irq !== 1'b1) begin $display("FAIL irq_rise: got %b want 1", irq); nerr++; end
    nvec++;
    apb_write(8'h00, 32'h0, e, ee);
    apb_write(8'h80, 32'h1, e, ee);
    if (irq !== 1'b1) begin $display("FAIL irq_hold: got %b want 1", irq); nerr++; end
    nvec++;
    idle(1);
    if (irq !== 1'b0) begin $display("FAIL irq_fall: got %b want 0", irq); nerr++; end
    nvec++;
  endtask
`endif

  task automatic test_random;
    logic [31:0] d, ed, wd;
    logic [7:0] a;
    bit e, ee, r;
    do_reset();
    for (int k = 0; k < 120; k++) begin
      a = addrs[$urandom_range(0, 12)] | 8'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0, 1: begin
          apb_read(a, d, e, r, ed, ee);
          if (d !== ed || e !== ee || r !== 1'b1) begin
            $display("FAIL rand_read[%h]: data=%h err=%b want %h/%b", a, d, e, ed, ee); nerr++;
          end
          nvec++;
        end
        2: begin
          wd = $urandom;
          apb_write(a, wd, e, ee);
          if (e !== ee) begin $display("FAIL rand_write[%h]: err=%b want %b", a, e, ee); nerr++; end
          nvec++;
        end
        default: idle($urandom_range(0, 6));
      endcase
`ifdef EVENT_IRQ_EN
      if (irq !== m_irq) begin $display("FAIL rand_irq: got %b want %b", irq, m_irq); nerr++; end
      nvec++;
`endif
    end
  endtask

  initial begin
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = 0; bus.pwdata = 0;
    test_reset();
    test_wrap();
    test_saturate();
    test_clear();
    test_errors();
    test_protocol();
    test_back_to_back();
`ifdef EVENT_IRQ_EN
    test_irq();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
